hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Central hazard/stall controller for the 5-stage MIPS pipeline.
- It is the initiator side of the EN/CLR control interface that the Decode→Execute pipeline register consumes.
- Generates fetch/decode stalls, the D/E register EN/CLR pair, the decode flush, and forwarding selects.
- Sequences multi-cycle multiply/divide occupancy and the exception flush/redirect.

Parameters:
- MD_CYCLES, 32, number of cycles a mult/div occupies Execute after start (≥2)
- EXC_FLUSH_CYCLES, 2, cycles CLR_E/FlushD are held after an exception is taken (≥1)
- WIDTH_5, 5, register-index width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs_D, Rt_D  in  5 each  decode source indices
- Rs_E, Rt_E  in  5 each  execute source indices
- WriteReg_E, WriteReg_M, WriteReg_W  in  5 each  destination index per stage
- RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  writeback enables per stage
- MemtoReg_E, MemtoReg_M  in  1 each  load-in-stage flags
- Branch_D, Jr_D  in  1 each  decode uses Rs/Rt for branch compare or jump target
- PCSrc_D  in  1  branch/jump taken in decode
- md_start_E  in  1  mult/div issued in Execute this cycle
- md_use_D  in  1  decode instruction reads HI/LO (mfhi/mflo/mult/div)
- exception_M  in  1  exception detected in Memory
- StallF  out  1  hold PC
- StallD  out  1  hold F/D register
- FlushD  out  1  clear F/D register
- EN_E  out  1  D/E register load enable
- CLR_E  out  1  D/E register bubble insert
- ForwardAE, ForwardBE  out  2 each  00 regfile, 01 from W, 10 from M
- ForwardAD, ForwardBD  out  1 each  forward M result to decode compare
- md_busy  out  1  mult/div unit occupied

Behaviour:
- Reset (async, rst_n=0): state=RUN, md_cnt=0, exc_cnt=0. Outputs: StallF=StallD=0, EN_E=0, CLR_E=1, FlushD=1, forwards=0, md_busy=0. Release is synchronous to the next rising edge.
- EN/CLR contract: the D/E register gives EN priority over CLR. The controller therefore never drives EN_E=1 and CLR_E=1 together. Bubble = EN_E=0, CLR_E=1. Hold = EN_E=0, CLR_E=0. Normal = EN_E=1, CLR_E=0.
- Forwarding (combinational, all states):
  - ForwardAE=10 if RegWrite_M && WriteReg_M!=0 && WriteReg_M==Rs_E.
  - Else ForwardAE=01 if the same condition holds for the W stage.
  - Else ForwardAE=00.
  - ForwardBE: same rules using Rt_E. M has priority over W.
  - ForwardAD = RegWrite_M && WriteReg_M!=0 && WriteReg_M==Rs_D. ForwardBD: same using Rt_D.
- lwstall = MemtoReg_E && RegWrite_E && (Rt_E==Rs_D || Rt_E==Rt_D).
- brstall = (Branch_D||Jr_D) && [ (RegWrite_E && WriteReg_E!=0 && WriteReg_E∈{Rs_D,Rt_D}) || (MemtoReg_M && WriteReg_M!=0 && WriteReg_M∈{Rs_D,Rt_D}) ].
- FSM states: RUN, MD_BUSY, EXC_FLUSH.
  - RUN:
    - If exception_M → EXC_FLUSH, exc_cnt=EXC_FLUSH_CYCLES-1.
    - Else if md_start_E → MD_BUSY, md_cnt=MD_CYCLES-1.
    - Outputs: stall = lwstall|brstall. StallF=StallD=stall. Bubble into D/E when stall, else normal. FlushD = PCSrc_D && !stall.
  - MD_BUSY:
    - md_busy=1.
    - If md_use_D: StallF=StallD=1 and bubble into D/E.
    - Otherwise the same rules as RUN apply. A new md_start_E while busy cannot occur (it is stalled) and is ignored.
    - md_cnt decrements each cycle; at md_cnt==0 → RUN, and md_busy drops in the same cycle as the transition.
  - EXC_FLUSH:
    - FlushD=1, bubble into D/E, StallF=0 (PC takes the vector).
    - exc_cnt decrements; at 0 → RUN.
    - Aborts any MD_BUSY: md_cnt cleared, md_busy=0.
- Simultaneous events:
  - exception_M has priority over md_start_E and over all stall terms.
  - A stall and PCSrc_D together: the stall wins and FlushD=0 until the stall clears.
- Register $0 never forwards and never causes a stall.
- Reset mid-operation: a mid-MD or mid-flush reset returns immediately to reset values. No partial state survives.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined: adds outputs stall_cycles[31:0], flush_cycles[31:0], md_cycles[31:0]. They are free-running saturating counters (hold at 0xFFFFFFFF) of cycles with StallD=1, FlushD=1, and md_busy=1 respectively. All three are cleared by rst_n.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum {RUN, MD_BUSY, EXC_FLUSH}
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - ZERO_REG=5'd0
- One natural sub-module: hazard_fwd_unit, purely combinational Forward*E/Forward*D logic, instantiated once.
- FSM, counters and stall logic stay in the top module.

Test Plan:
- Load-use: lw to $8 in E (MemtoReg_E=1, Rt_E=8), Rs_D=8 → one cycle StallF=StallD=1, EN_E=0, CLR_E=1; next cycle ForwardAE=01.
- Forward priority: RegWrite_M=RegWrite_W=1, WriteReg_M=WriteReg_W=5, Rs_E=5 → ForwardAE=10. Same case with WriteReg_M=0, WriteReg_W=0, Rs_E=0 → ForwardAE=00.
- Mult/div, MD_CYCLES=4: md_start_E pulse, then md_use_D=1 → md_busy high for exactly 4 cycles, decode stalled for those 4, EN_E=1 on the fifth.
- Exception during MD_BUSY: exception_M at busy cycle 2 → md_busy=0 next cycle, FlushD=1 and CLR_E=1/EN_E=0 for 2 cycles, then RUN.
- Branch hazard: Branch_D=1, Rs_D=3, RegWrite_E=1, WriteReg_E=3, PCSrc_D=1 → stall 1 cycle with FlushD=0, then FlushD=1.
- Async reset mid-flush: rst_n low between edges → CLR_E=1, FlushD=1, EN_E=0 immediately; after release, RUN with no residual flush.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;
    typedef enum logic [1:0] {RUN, MD_BUSY, EXC_FLUSH} state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding selects for Execute operands and the Decode branch compare.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] rs_d_i,
    input  logic [W-1:0] rt_d_i,
    input  logic [W-1:0] rs_e_i,
    input  logic [W-1:0] rt_e_i,
    input  logic [W-1:0] wreg_m_i,
    input  logic [W-1:0] wreg_w_i,
    input  logic         regwr_m_i,
    input  logic         regwr_w_i,
    output logic [1:0]   fwd_ae_o,
    output logic [1:0]   fwd_be_o,
    output logic         fwd_ad_o,
    output logic         fwd_bd_o
);
    logic m_live, w_live;

    // $0 is hardwired, so a write to it never produces a usable result.
    assign m_live = regwr_m_i && (wreg_m_i != W'(ZERO_REG));
    assign w_live = regwr_w_i && (wreg_w_i != W'(ZERO_REG));

    always_comb begin
        fwd_ae_o = FWD_RF;
        fwd_be_o = FWD_RF;
        if (m_live && wreg_m_i == rs_e_i)      fwd_ae_o = FWD_M;
        else if (w_live && wreg_w_i == rs_e_i) fwd_ae_o = FWD_W;
        if (m_live && wreg_m_i == rt_e_i)      fwd_be_o = FWD_M;
        else if (w_live && wreg_w_i == rt_e_i) fwd_be_o = FWD_W;
    end

    assign fwd_ad_o = m_live && (wreg_m_i == rs_d_i);
    assign fwd_bd_o = m_live && (wreg_m_i == rt_d_i);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: stalls, D/E EN/CLR, decode flush, forwarding, mult/div and exception sequencing.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush/mult-div cycle counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES        = 32,
    parameter int EXC_FLUSH_CYCLES = 2,
    parameter int WIDTH_5          = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH_5-1:0] Rs_D,
    input  logic [WIDTH_5-1:0] Rt_D,
    input  logic [WIDTH_5-1:0] Rs_E,
    input  logic [WIDTH_5-1:0] Rt_E,
    input  logic [WIDTH_5-1:0] WriteReg_E,
    input  logic [WIDTH_5-1:0] WriteReg_M,
    input  logic [WIDTH_5-1:0] WriteReg_W,
    input  logic               RegWrite_E,
    input  logic               RegWrite_M,
    input  logic               RegWrite_W,
    input  logic               MemtoReg_E,
    input  logic               MemtoReg_M,
    input  logic               Branch_D,
    input  logic               Jr_D,
    input  logic               PCSrc_D,
    input  logic               md_start_E,
    input  logic               md_use_D,
    input  logic               exception_M,
    output logic               StallF,
    output logic               StallD,
    output logic               FlushD,
    output logic               EN_E,
    output logic               CLR_E,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic               ForwardAD,
    output logic               ForwardBD,
    output logic               md_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_cycles,
    output logic [31:0]        md_cycles
`endif
);
    localparam int MD_W  = $clog2(MD_CYCLES + 1);
    localparam int EXC_W = $clog2(EXC_FLUSH_CYCLES + 1);
    localparam logic [WIDTH_5-1:0] Z = WIDTH_5'(ZERO_REG);

    state_e           state_q, state_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [EXC_W-1:0] exc_cnt_q, exc_cnt_d;

    logic [1:0] fae, fbe;
    logic       fad, fbd;
    logic       lwstall, brstall, e_hit, m_hit, stall, hold;

    hazard_fwd_unit #(.W(WIDTH_5)) u_fwd (
        .rs_d_i   (Rs_D),
        .rt_d_i   (Rt_D),
        .rs_e_i   (Rs_E),
        .rt_e_i   (Rt_E),
        .wreg_m_i (WriteReg_M),
        .wreg_w_i (WriteReg_W),
        .regwr_m_i(RegWrite_M),
        .regwr_w_i(RegWrite_W),
        .fwd_ae_o (fae),
        .fwd_be_o (fbe),
        .fwd_ad_o (fad),
        .fwd_bd_o (fbd)
    );

    assign ForwardAE = rst_n ? fae : FWD_RF;
    assign ForwardBE = rst_n ? fbe : FWD_RF;
    assign ForwardAD = rst_n && fad;
    assign ForwardBD = rst_n && fbd;

    assign lwstall = MemtoReg_E && RegWrite_E && (Rt_E != Z) && (Rt_E == Rs_D || Rt_E == Rt_D);
    assign e_hit   = RegWrite_E && (WriteReg_E != Z) && (WriteReg_E == Rs_D || WriteReg_E == Rt_D);
    assign m_hit   = MemtoReg_M && (WriteReg_M != Z) && (WriteReg_M == Rs_D || WriteReg_M == Rt_D);
    assign brstall = (Branch_D || Jr_D) && (e_hit || m_hit);
    assign stall   = lwstall || brstall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            md_cnt_q  <= '0;
            exc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        exc_cnt_d = exc_cnt_q;
        hold      = stall;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        EN_E      = 1'b1;
        CLR_E     = 1'b0;
        md_busy   = 1'b0;
        unique case (state_q)
            RUN, MD_BUSY: begin
                // While busy, an HI/LO reader waits in decode like any other stall.
                if (state_q == MD_BUSY) begin
                    md_busy = 1'b1;
                    hold    = stall || md_use_D;
                end
                StallF = hold;
                StallD = hold;
                EN_E   = !hold;
                CLR_E  = hold;
                FlushD = PCSrc_D && !hold;
                if (exception_M) begin
                    state_d   = EXC_FLUSH;
                    exc_cnt_d = EXC_W'(EXC_FLUSH_CYCLES - 1);
                    md_cnt_d  = '0;
                end else if (state_q == RUN) begin
                    if (md_start_E) begin
                        state_d  = MD_BUSY;
                        md_cnt_d = MD_W'(MD_CYCLES - 1);
                    end
                end else if (md_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
            EXC_FLUSH: begin
                FlushD   = 1'b1;
                EN_E     = 1'b0;
                CLR_E    = 1'b1;
                md_cnt_d = '0;
                if (exc_cnt_q == '0) state_d = RUN;
                else                 exc_cnt_d = exc_cnt_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
        // Reset forces a bubble/flush immediately, independent of the clock.
        if (!rst_n) begin
            StallF  = 1'b0;
            StallD  = 1'b0;
            FlushD  = 1'b1;
            EN_E    = 1'b0;
            CLR_E   = 1'b1;
            md_busy = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
            md_cycles    <= '0;
        end else begin
            if (StallD && stall_cycles != '1)  stall_cycles <= stall_cycles + 1'b1;
            if (FlushD && flush_cycles != '1)  flush_cycles <= flush_cycles + 1'b1;
            if (md_busy && md_cycles != '1)    md_cycles    <= md_cycles + 1'b1;
        end
    end
`endif
endmodule
